// File: rtl/prog2_2.sv
// prog2_2: 4-input truth-table function with registered copies; PROG2_2_HIT_CNT_EN adds a saturating hit counter
module prog2_2 #(
    parameter logic [15:0] TRUTH_TABLE = 16'h0727
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       a,
    input  logic       b,
    input  logic       c,
    input  logic       d,
    output logic       f,
    output logic       f_q,
    output logic [3:0] idx_q,
    output logic       f_chg
`ifdef PROG2_2_HIT_CNT_EN
    ,
    output logic [7:0] hit_cnt
`endif
);
    logic [3:0] idx;
    assign idx = {a, b, c, d};
    assign f   = TRUTH_TABLE[idx];
    // capture inputs and result; flag a change of the registered result
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            idx_q <= 4'h0;
            f_q   <= 1'b0;
            f_chg <= 1'b0;
        end else begin
            idx_q <= idx;
            f_q   <= f;
            f_chg <= f != f_q;
        end
`ifdef PROG2_2_HIT_CNT_EN
    // count edges that load a 1 into f_q, holding at full scale
    always_ff @(posedge clk or posedge rst)
        if (rst)
            hit_cnt <= 8'h00;
        else if (f && hit_cnt != 8'hFF)
            hit_cnt <= hit_cnt + 8'd1;
`endif
endmodule

// File: tb/tb_prog2_2.sv
// tb_prog2_2: directed checks of prog2_2 combinational, registered, reset and optional counter behaviour
module tb_prog2_2;
    logic       clk = 1'b0;
    logic       clk_en = 1'b0;
    logic       rst = 1'b1;
    logic       a = 1'b0, b = 1'b0, c = 1'b0, d = 1'b0;
    logic       f, f_q, f_chg;
    logic [3:0] idx_q;
    logic       f2, f_q2, f_chg2;
    logic [3:0] idx_q2;
`ifdef PROG2_2_HIT_CNT_EN
    logic [7:0] hit_cnt, hit_cnt2;
`endif
    int total = 0;
    int bad = 0;
    bit exp_f [16] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0,
                       1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

    prog2_2 u_dut (
        .clk(clk), .rst(rst), .a(a), .b(b), .c(c), .d(d),
        .f(f), .f_q(f_q), .idx_q(idx_q), .f_chg(f_chg)
`ifdef PROG2_2_HIT_CNT_EN
        , .hit_cnt(hit_cnt)
`endif
    );

    prog2_2 #(.TRUTH_TABLE(16'h8000)) u_alt (
        .clk(clk), .rst(rst), .a(a), .b(b), .c(c), .d(d),
        .f(f2), .f_q(f_q2), .idx_q(idx_q2), .f_chg(f_chg2)
`ifdef PROG2_2_HIT_CNT_EN
        , .hit_cnt(hit_cnt2)
`endif
    );

    always #5 if (clk_en) clk = ~clk;

    task automatic set_idx(input int i);
        {a, b, c, d} = 4'(i);
    endtask

    task automatic test_reset;
        #1;
        total++;
        if (f_q !== 1'b0 || idx_q !== 4'h0 || f_chg !== 1'b0) begin
            bad++;
            $display("FAIL reset_state: f_q=%b idx_q=%h f_chg=%b want 0 0 0", f_q, idx_q, f_chg);
        end
    endtask

    task automatic test_comb_sweep;
        for (int i = 0; i < 16; i++) begin
            set_idx(i);
            #20;
            total++;
            if (f !== exp_f[i]) begin
                bad++;
                $display("FAIL comb_f idx=%0d: got %b want %b", i, f, exp_f[i]);
            end
            total++;
            if (f2 !== (i == 15)) begin
                bad++;
                $display("FAIL alt_f idx=%0d: got %b want %b", i, f2, i == 15);
            end
        end
        total++;
        if (idx_q !== 4'h0 || f_q !== 1'b0) begin
            bad++;
            $display("FAIL comb_no_clock: idx_q=%h f_q=%b want 0 0", idx_q, f_q);
        end
    endtask

    task automatic test_registered;
        bit prev;
        rst = 1'b0;
        clk_en = 1'b1;
        set_idx(0);
        @(posedge clk);
        #1;
        prev = 1'b1;
        for (int i = 0; i < 16; i++) begin
            set_idx(i);
            @(posedge clk);
            #1;
            total++;
            if (idx_q !== 4'(i) || f_q !== exp_f[i] || f_chg !== (exp_f[i] != prev)) begin
                bad++;
                $display("FAIL reg_sweep idx=%0d: idx_q=%h f_q=%b f_chg=%b want %h %b %b",
                         i, idx_q, f_q, f_chg, 4'(i), exp_f[i], exp_f[i] != prev);
            end
            total++;
            if (f_q2 !== (i == 15)) begin
                bad++;
                $display("FAIL alt_f_q idx=%0d: got %b want %b", i, f_q2, i == 15);
            end
            prev = exp_f[i];
        end
    endtask

    task automatic test_async_reset;
        set_idx(5);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        total++;
        if (f_q !== 1'b1 || f_chg !== 1'b0 || idx_q !== 4'h5) begin
            bad++;
            $display("FAIL hold: f_q=%b f_chg=%b idx_q=%h want 1 0 5", f_q, f_chg, idx_q);
        end
        #2 rst = 1'b1;
        #1;
        total++;
        if (f_q !== 1'b0 || idx_q !== 4'h0 || f_chg !== 1'b0) begin
            bad++;
            $display("FAIL async_reset: f_q=%b idx_q=%h f_chg=%b want 0 0 0", f_q, idx_q, f_chg);
        end
        set_idx(4);
        #1;
        total++;
        if (f !== 1'b0) begin
            bad++;
            $display("FAIL f_in_reset idx=4: got %b want 0", f);
        end
        set_idx(9);
        #1;
        total++;
        if (f !== 1'b1) begin
            bad++;
            $display("FAIL f_in_reset idx=9: got %b want 1", f);
        end
    endtask

    task automatic test_reset_release;
        set_idx(0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        total++;
        if (f_q !== 1'b1 || f_chg !== 1'b1 || idx_q !== 4'h0) begin
            bad++;
            $display("FAIL release: f_q=%b f_chg=%b idx_q=%h want 1 1 0", f_q, f_chg, idx_q);
        end
        @(posedge clk);
        #1;
        total++;
        if (f_chg !== 1'b0) begin
            bad++;
            $display("FAIL chg_one_cycle: got %b want 0", f_chg);
        end
    endtask

`ifdef PROG2_2_HIT_CNT_EN
    task automatic test_hit_cnt;
        @(negedge clk);
        rst = 1'b1;
        #1;
        set_idx(0);
        @(negedge clk);
        rst = 1'b0;
        for (int n = 1; n <= 300; n++) begin
            @(posedge clk);
            #1;
            if (n == 1 || n == 255 || n == 300) begin
                total++;
                if (hit_cnt !== 8'((n > 255) ? 255 : n)) begin
                    bad++;
                    $display("FAIL hit_cnt n=%0d: got %0d want %0d", n, hit_cnt, (n > 255) ? 255 : n);
                end
            end
        end
        total++;
        if (hit_cnt2 !== 8'h00) begin
            bad++;
            $display("FAIL alt_hit_cnt: got %0d want 0", hit_cnt2);
        end
        #2 rst = 1'b1;
        #1;
        total++;
        if (hit_cnt !== 8'h00) begin
            bad++;
            $display("FAIL hit_cnt_reset: got %0d want 0", hit_cnt);
        end
        rst = 1'b0;
    endtask
`endif

    initial begin
        test_reset;
        test_comb_sweep;
        test_registered;
        test_async_reset;
        test_reset_release;
`ifdef PROG2_2_HIT_CNT_EN
        test_hit_cnt;
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
